// File: rtl/me_block_loader.sv
// Stream loader for Me_engine: fills the current-block and reference-window memories, then runs go/done.
// Optional watchdog on the go/done handshake is built when ME_LOADER_TIMEOUT_EN is defined.
module me_block_loader #(
    parameter int CUR_WORDS      = 32,
    parameter int REF_WORDS      = 128,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [63:0]                  in_data,
    input  logic [1:0]                   cfg_r,
    output logic [1:0]                   r,
    output logic [$clog2(CUR_WORDS)-1:0] address_write_cur,
    output logic [63:0]                  data_write_cur,
    output logic                         write_enable_cur,
    output logic [$clog2(REF_WORDS)-1:0] address_write_ref,
    output logic [63:0]                  data_write_ref,
    output logic                         write_enable_ref,
    output logic                         go,
    input  logic                         done,
    output logic [15:0]                  block_count,
    output logic                         timeout
);
    localparam int CUR_AW = $clog2(CUR_WORDS);
    localparam int REF_AW = $clog2(REF_WORDS);
    localparam int CNT_W  = (CUR_AW > REF_AW) ? CUR_AW : REF_AW;
    localparam logic [CNT_W-1:0] CUR_LAST = CNT_W'(CUR_WORDS - 1);
    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REF_WORDS - 1);

    typedef enum logic [2:0] {LOAD_CUR, LOAD_REF, FLUSH, RUN, RELEASE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                in_ready_q;
    logic [1:0]          r_q;
    logic [CUR_AW-1:0]   addr_cur_q;
    logic [63:0]         data_cur_q;
    logic                we_cur_q;
    logic [REF_AW-1:0]   addr_ref_q;
    logic [63:0]         data_ref_q;
    logic                we_ref_q;
    logic                go_q;
    logic [15:0]         block_count_q;
    logic                accept;
    logic                accept_cur;
    logic                accept_ref;
    logic                finish;
    logic                timeout_hit;

    assign accept     = in_valid && in_ready_q;
    assign accept_cur = accept && (state_q == LOAD_CUR);
    assign accept_ref = accept && (state_q == LOAD_REF);
    assign finish     = (state_q == RUN) && done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD_CUR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOAD_CUR: if (accept) begin
                if (cnt_q == CUR_LAST) begin
                    state_d = LOAD_REF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOAD_REF: if (accept) begin
                if (cnt_q == REF_LAST) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FLUSH:    state_d = RUN;
            RUN:      if (done || timeout_hit) state_d = RELEASE;
            RELEASE:  if (!done) state_d = LOAD_CUR;
            default:  state_d = LOAD_CUR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_q    <= 1'b0;
            r_q           <= '0;
            addr_cur_q    <= '0;
            data_cur_q    <= '0;
            we_cur_q      <= 1'b0;
            addr_ref_q    <= '0;
            data_ref_q    <= '0;
            we_ref_q      <= 1'b0;
            go_q          <= 1'b0;
            block_count_q <= '0;
        end else begin
            in_ready_q <= (state_d == LOAD_CUR) || (state_d == LOAD_REF);
            // go is delayed one cycle behind RUN entry and drops on the completing edge.
            go_q       <= (state_q == RUN) && (state_d == RUN);
            we_cur_q   <= accept_cur;
            we_ref_q   <= accept_ref;
            if (accept_cur) begin
                addr_cur_q <= cnt_q[CUR_AW-1:0];
                data_cur_q <= in_data;
                if (cnt_q == '0) r_q <= cfg_r;
            end
            if (accept_ref) begin
                addr_ref_q <= cnt_q[REF_AW-1:0];
                data_ref_q <= in_data;
            end
            if (finish) block_count_q <= block_count_q + 16'd1;
        end
    end

`ifdef ME_LOADER_TIMEOUT_EN
    logic [31:0] run_cnt_q;
    logic        timeout_q;

    assign timeout_hit = (state_q == RUN) && (run_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            run_cnt_q <= (state_q == RUN) ? run_cnt_q + 32'd1 : 32'd0;
            // A done landing on the same edge wins: that block counts as completed.
            timeout_q <= timeout_hit && !done;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout     = 1'b0;
`endif

    assign in_ready          = in_ready_q;
    assign r                 = r_q;
    assign address_write_cur = addr_cur_q;
    assign data_write_cur    = data_cur_q;
    assign write_enable_cur  = we_cur_q;
    assign address_write_ref = addr_ref_q;
    assign data_write_ref    = data_ref_q;
    assign write_enable_ref  = we_ref_q;
    assign go                = go_q;
    assign block_count       = block_count_q;
endmodule

// File: doc/me_block_loader.md
# me_block_loader

Streaming front end for `Me_engine`. It accepts 64-bit words of eight 8-bit pixels over a valid/ready stream. The first CUR_WORDS beats are written into the engine's current-block memory and the next REF_WORDS beats into its reference-window memory. It then raises `go`, holds it until the engine reports `done`, and rearms for the next block. It sits directly upstream of `Me_engine` and replaces bench-driven memory loading in the integrated design.

## Interface
- CUR_WORDS, 32, words per current block (16x16 pixels, 2 words/row); power of two, ≥2
- REF_WORDS, 128, words per reference window (32x32 pixels, 4 words/row); power of two, ≥2
- TIMEOUT_CYCLES, 4096, maximum cycles to wait for `done` (used only with ME_LOADER_TIMEOUT_EN)
- `clk` in 1: single clock; all logic on rising edge
- `reset` in 1: synchronous, active-high
- `in_valid` in 1: stream word valid
- `in_ready` out 1: loader accepts word this cycle
- `in_data` in 64: pixel p0 in [7:0] … p7 in [63:56]
- `cfg_r` in 2: search-range code; captured on first beat of each block
- `r` out 2: latched search-range code to engine
- `address_write_cur` out $clog2(CUR_WORDS) (5): cur memory address
- `data_write_cur` out 64: cur memory data
- `write_enable_cur` out 1: cur memory write strobe
- `address_write_ref` out $clog2(REF_WORDS) (7): ref memory address
- `data_write_ref` out 64: ref memory data
- `write_enable_ref` out 1: ref memory write strobe
- `go` out 1: start level to engine
- `done` in 1: engine completion
- `block_count` out 16: blocks completed
- `timeout` out 1: one-cycle watchdog pulse

## Operation
- Handshake: a beat transfers on a rising edge with `in_valid && in_ready`. `in_data` is ignored otherwise.
- `in_ready` = (state==LOAD_CUR || state==LOAD_REF). It is a pure function of registered state.
- States:
  - LOAD_CUR: count beats 0..CUR_WORDS-1. Last beat → LOAD_REF.
  - LOAD_REF: count beats 0..REF_WORDS-1. Last beat → FLUSH.
  - FLUSH: one cycle, no accept. → RUN.
  - RUN: `go`=1. `done`=1 → RELEASE and `block_count`+1.
  - RELEASE: `go`=0. Waits for `done`==0, then → LOAD_CUR.
- Address generation: beat k of a phase is written to address k, linear. The cur row is k/2; the ref row is k/4.
- Counters reset to 0 on each phase entry. They never wrap inside a phase.
- `cfg_r` is sampled on beat 0 of LOAD_CUR into `r`. `r` holds until the next block's beat 0.
- `block_count` wraps 0xFFFF→0x0000.
- Outputs are registered. Address and data outputs hold their last value when the strobe is low.
- Reset, at any time including mid-block:
  - state → LOAD_CUR, counters 0
  - all outputs 0 (`in_ready` becomes 1 the cycle after reset deasserts)
  - a partial block is discarded; the next beat is cur address 0.

## Timing
- Write latency: a beat accepted at edge N produces its strobe, address and data during cycle N..N+1, i.e. visible one cycle after acceptance. Each strobe lasts exactly one cycle per beat.
- No bubbles are inserted: continuous `in_valid` gives CUR_WORDS+REF_WORDS consecutive accept cycles.
- `in_ready` stays high across the cur→ref boundary.
- `go` rises exactly one cycle after the last `write_enable_ref` cycle.
- `go` falls the cycle after `done` is sampled high in RUN.
- Minimum gap from `done` high to `in_ready` high is 2 cycles, when `done` is a 1-cycle pulse.
- `done` in any state other than RUN is ignored.

## Configuration
- `ME_LOADER_TIMEOUT_EN` defined:
  - a 32-bit cycle counter runs in RUN and clears on RUN entry.
  - Reaching TIMEOUT_CYCLES with no `done` pulses `timeout` for 1 cycle, drops `go` and enters RELEASE.
  - `block_count` does not increment on a timeout.
  - `done` and the timeout landing in the same cycle count as completion, not timeout.
- Undefined: no counter is built, `timeout` is tied 0, and RUN waits indefinitely.

## Test plan
- Reset, then 160 continuous beats with `in_data`=beat index:
  - cur writes at addresses 0..31 carry data 0..31
  - ref writes at addresses 0..127 carry data 32..159
  - `go` rises 2 cycles after the last accept edge.
- `in_valid` toggling every cycle: strobes only follow accepted beats, addresses stay contiguous with no skips or duplicates, and the total is still 32+128.
- `cfg_r`=2'b10 at beat 0, then 2'b01 afterwards: `r`=2'b10 for the whole block.
- 1-cycle `done` 3 cycles after `go`: `go` falls next cycle, `block_count`=1, `in_ready`=1 two cycles after `done`.
- `done` held high for 5 cycles: the block stays in RELEASE with `in_ready`=0 until `done` falls; `block_count` increments only once.
- `reset` after 10 cur beats: all outputs are 0 next cycle, and a fresh stream starts at cur address 0.
- With ME_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16, no `done`: `timeout` pulses on the 16th RUN cycle, `go` falls, `block_count` is unchanged, and the next block loads normally.
